// File: rtl/sample_loader.sv
// Streams a frame of samples into a sample memory and hands the full frame to a compute FSM.
// Optional feature: define LOADER_ZERO_PAD_EN to zero-fill a frame that ends early on s_last.
module sample_loader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [ADDR_W-1:0] sample_num,
   input  logic              start,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              data_loaded,
   input  logic              load_nCompute,
   input  logic              calc_end,
   output logic              busy,
   output logic [2:0]        state
);

   localparam logic [2:0] S_IDLE      = 3'b000;
   localparam logic [2:0] S_FILL      = 3'b001;
   localparam logic [2:0] S_PAD       = 3'b010;
   localparam logic [2:0] S_HANDOFF   = 3'b011;
   localparam logic [2:0] S_WAIT_CALC = 3'b100;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] num_q, num_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              data_loaded_q, data_loaded_d;
   logic [ADDR_W-1:0] last_idx_s;
   logic              xfer_s;

   // A latched sample_num of 0 wraps to the all-ones index, giving a 2^ADDR_W frame.
   assign last_idx_s = num_q - {{(ADDR_W-1){1'b0}}, 1'b1};
   assign s_ready    = ce & (state_q == S_FILL);
   assign xfer_s     = s_valid & s_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (ce) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_FILL;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FILL: begin
               if (xfer_s && (count_q == last_idx_s)) begin
                  state_d = S_HANDOFF;
`ifdef LOADER_ZERO_PAD_EN
               end else if (xfer_s && s_last && (count_q < last_idx_s)) begin
                  state_d = S_PAD;
`endif
               end else begin
                  state_d = S_FILL;
               end
            end
`ifdef LOADER_ZERO_PAD_EN
            S_PAD: begin
               if (count_q == last_idx_s) begin
                  state_d = S_HANDOFF;
               end else begin
                  state_d = S_PAD;
               end
            end
`endif
            S_HANDOFF: begin
               if (!load_nCompute) begin
                  state_d = S_WAIT_CALC;
               end else begin
                  state_d = S_HANDOFF;
               end
            end
            S_WAIT_CALC: begin
               if (calc_end) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT_CALC;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Datapath and registered-output next values
   always_comb begin
      count_d       = count_q;
      num_d         = num_q;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      data_loaded_d = data_loaded_q;
      if (ce) begin
         // Raised on the same edge as the final write, so it never leads mem_we.
         data_loaded_d = (state_d == S_HANDOFF);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  num_d   = sample_num;
                  count_d = {ADDR_W{1'b0}};
               end else begin
                  num_d   = num_q;
               end
            end
            S_FILL: begin
               if (xfer_s) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = count_q;
                  mem_wdata_d = s_data;
                  count_d     = count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end else begin
                  mem_we_d    = 1'b0;
               end
            end
`ifdef LOADER_ZERO_PAD_EN
            S_PAD: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = count_q;
               mem_wdata_d = {DATA_W{1'b0}};
               count_d     = count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
`endif
            default: begin
               mem_we_d = 1'b0;
            end
         endcase
      end else begin
         mem_we_d = 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q       <= {ADDR_W{1'b0}};
         num_q         <= {ADDR_W{1'b0}};
         mem_we_q      <= 1'b0;
         mem_addr_q    <= {ADDR_W{1'b0}};
         mem_wdata_q   <= {DATA_W{1'b0}};
         data_loaded_q <= 1'b0;
      end else begin
         count_q       <= count_d;
         num_q         <= num_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         data_loaded_q <= data_loaded_d;
      end
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign data_loaded = data_loaded_q;
   assign busy        = (state_q != S_IDLE);
   assign state       = state_q;

endmodule
